// File: rtl/bsg_aes_block_assembler.sv
// Assembles ring words into a 128-bit key and a 128-bit plaintext block,
// then offers the pair to the AES encryptor over a valid/ready handshake.
module bsg_aes_block_assembler #(
    parameter int unsigned ring_width_p    = 75,
    parameter bit          key_sticky_p    = 1'b1,
    parameter int unsigned dup_cnt_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [ring_width_p-1:0]    data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [127:0]               key_o,
    output logic [127:0]               pt_o,
    input  logic                       ready_i,
    output logic [dup_cnt_width_p-1:0] dup_cnt_o
);

    localparam int unsigned word_w_lp  = 32;
    localparam int unsigned words_lp   = 8;
    localparam int unsigned blk_w_lp   = word_w_lp * words_lp;
    localparam logic [words_lp-1:0] issue_mask_lp = key_sticky_p ? 8'h0F : 8'h00;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } state_e;

    state_e                      state_r, state_n;
    logic [words_lp-1:0]         mask_r, mask_n;
    logic [blk_w_lp-1:0]         blk_r, blk_n;
    logic [dup_cnt_width_p-1:0]  dup_n;
    logic                        accept, dup;
    logic [word_w_lp-1:0]        word;
    logic [2:0]                  idx;
    logic                        start;
    logic [7:0]                  bit_base;
    logic                        unused_hi;

    // Ring payload fields; bits above the start flag are don't-care.
    assign word      = data_i[31:0];
    assign idx       = data_i[34:32];
    assign start     = data_i[35];
    assign unused_hi = ^data_i[ring_width_p-1:36];

    // Word 0 lands in the top 32 bits of {key, pt}; word 7 in the bottom.
    assign bit_base  = {~idx, 5'b0_0000};

    // Next-state, mask, storage and duplicate-count update.
    always_comb begin
        state_n = state_r;
        mask_n  = mask_r;
        blk_n   = blk_r;
        dup_n   = dup_cnt_o;
        accept  = 1'b0;
        dup     = 1'b0;
        case (state_r)
            COLLECT: begin
                accept = v_i & ready_o;
                if (accept) begin
                    dup    = ~start & mask_r[idx];
                    mask_n = (start ? 8'h00 : mask_r) | (8'(1) << idx);
                    blk_n[bit_base +: word_w_lp] = word;
                    if (dup && (dup_cnt_o != '1)) begin
                        dup_n = dup_cnt_o + dup_cnt_width_p'(1);
                    end
                end
                if (mask_n == 8'hFF) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (ready_i) begin
                    state_n = COLLECT;
                    mask_n  = issue_mask_lp;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // State and datapath registers; handshake outputs follow the next state.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= COLLECT;
            mask_r    <= '0;
            blk_r     <= '0;
            dup_cnt_o <= '0;
            v_o       <= 1'b0;
            ready_o   <= 1'b0;
        end else begin
            state_r   <= state_n;
            mask_r    <= mask_n;
            blk_r     <= blk_n;
            dup_cnt_o <= dup_n;
            v_o       <= (state_n == ISSUE);
            ready_o   <= (state_n == COLLECT);
        end
    end

    assign key_o = blk_r[blk_w_lp-1 -: 128];
    assign pt_o  = blk_r[127:0];

endmodule

// File: doc/bsg_aes_block_assembler.md
Name: bsg_aes_block_assembler

Overview:
Ingress stage placed directly upstream of the AES encrypt node inside a test node client. It accepts 32-bit words from ring packets and assembles them into a 128-bit key and a 128-bit plaintext block. It then issues the pair to the encryptor over a valid/ready handshake. The key can be retained across blocks, so that streaming plaintext needs only four words per block.

Parameters:
ring_width_p, 75, width of data_i; only bits [35:0] are decoded, the rest are ignored.
key_sticky_p, 1, if 1 the key is retained after an issue; if 0 all eight words must be reloaded for every block.
dup_cnt_width_p, 8, width of the saturating duplicate-write counter.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous reset, active-low
v_i  in  1  input word valid
data_i  in  ring_width_p  [31:0] word, [34:32] word index, [35] start flag
ready_o  out  1  assembler can accept a word
v_o  out  1  key/plaintext pair valid
key_o  out  128  assembled key
pt_o  out  128  assembled plaintext
ready_i  in  1  encryptor accepts the pair
dup_cnt_o  out  dup_cnt_width_p  count of overwrites of already-loaded words

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low: sampled on the rising edge of clk_i while reset_n_i=0.
  - Reset values: state=COLLECT, mask=8'h00, v_o=0, ready_o=0 while reset_n_i=0, dup_cnt_o=0.
  - key_o and pt_o registers are cleared to 0.
  - Reset in any state, including ISSUE with v_o=1, aborts the operation; the pending pair is dropped.
- Accept: a word is accepted on a cycle with v_i & ready_o.
- Word map:
  - Index 0..3 write key_o[127:96], [95:64], [63:32], [31:0].
  - Index 4..7 write pt_o[127:96] .. pt_o[31:0].
  - The most-significant word comes first.
- 8-bit mask register: bit k is set when word k is written.
- Start flag (data_i[35]=1 on an accepted word):
  - The mask is cleared before the word is written, so after that cycle mask has only bit idx set.
  - Start never increments dup_cnt_o.
- Duplicate write:
  - An accepted word without the start flag whose mask bit is already 1 overwrites the stored word.
  - dup_cnt_o increments, saturating at all-ones.
- State machine:
  - COLLECT: ready_o=1, v_o=0. On the clock edge after the mask becomes 8'hFF (including via the accepting word itself), go to ISSUE.
  - ISSUE: v_o=1, ready_o=0, so no input is accepted. key_o and pt_o are stable while v_o=1. Hold until ready_i=1.
  - On v_o & ready_i: next state is COLLECT.
    - key_sticky_p=1: the mask becomes 8'h0F (key kept).
    - key_sticky_p=0: the mask becomes 8'h00.
    - key_o and pt_o registers keep their values until overwritten.
- Latency and throughput:
  - The last word accepted in cycle t gives v_o=1 at t+1.
  - With ready_i=1 at t+1, ready_o=1 again at t+2.
  - Minimum period per block in sticky steady state: 4 accept cycles + 1 issue cycle.
- ready_i has no effect in COLLECT.
- v_i has no effect while ready_o=0.

Test Plan:
- Reset, then 8 words idx0..7 with values 32'h00010203..32'h1C1D1E1F, start on idx0, ready_i=1 -> v_o=1 for exactly one cycle, one cycle after idx7. key_o=128'h000102030405060708090A0B0C0D0E0F. pt_o=128'h101112131415161718191A1B1C1D1E1F. dup_cnt_o=0.
- key_sticky_p=1: after the first issue, send only idx4..7 = 32'hAAAAAAAA -> v_o=1, key_o unchanged, pt_o=128'hAAAA...AA. With key_sticky_p=0, the same stimulus -> v_o stays 0.
- Backpressure: complete a block with ready_i=0 for 5 cycles -> v_o=1 and ready_o=0 for all 5 cycles. Outputs are stable and input words offered during ISSUE are ignored. ready_i=1 -> v_o=0 next cycle.
- Duplicates: write idx2 three times without start, 260 duplicate writes total -> dup_cnt_o saturates at 8'hFF. The last value written to idx2 appears in key_o[63:32].
- Start flush: load idx0..5, then send idx3 with start=1, then idx4..7 -> v_o stays 0 (mask=8'hF8). Sending idx0,1,2 -> v_o=1.
- Reset mid-operation: drive reset_n_i=0 for one cycle during COLLECT (mask=8'h3F) and again during ISSUE -> v_o=0 and ready_o=0 during reset. After reset a full 8-word load is required before v_o=1.
